// File: rtl/srt4_param_divider_if.sv
// Operand/result bus of srt4_param_divider: start strobe, serial operand input,
// registered result output and status flags.
interface srt4_param_divider_if #(
  parameter int WIDTH = 8
);
  logic             beginSignal;
  logic [WIDTH-1:0] inbus;
  logic [WIDTH-1:0] outbus;
  logic             endSignal;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output beginSignal,
    output inbus,
    input  outbus,
    input  endSignal,
    input  busy,
    input  div_by_zero
  );

  modport slave (
    input  beginSignal,
    input  inbus,
    output outbus,
    output endSignal,
    output busy,
    output div_by_zero
  );
endinterface

// File: rtl/srt4_param_divider.sv
// Radix-4 SRT divider: serial operand load, divisor normalisation, on-the-fly quotient
// conversion, remainder correction/denormalisation. Define SRT4_SIGNED_EN for two's complement.
module srt4_param_divider #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  srt4_param_divider_if.slave bus
);

  localparam int PW   = WIDTH + 3;
  localparam int KW   = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;
  localparam logic [KW-1:0] LAST_ITER = KW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LOAD_B, NORM, ITER, CORR, DENORM, OUT_Q, OUT_R} state_e;
  typedef enum logic [2:0] {D_M2, D_M1, D_Z, D_P1, D_P2} digit_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef SRT4_SIGNED_EN
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`endif

  logic [PW-1:0]    b_ext;
  logic [PW-1:0]    w_shift;
  logic signed [5:0] w_est;
  logic signed [5:0] m2, m1;
  digit_e           digit;
  logic [PW-1:0]    p_iter;
  logic [WIDTH-1:0] qa_iter, qm_iter;
  logic [WIDTH-1:0] rem_mag;

  assign b_ext   = {3'b000, b_q};
  assign w_shift = {p_q[PW-3:0], a_q[WIDTH-1 -: 2]};
  assign w_est   = $signed(w_shift[PW-1 -: 6]);
  assign rem_mag = p_q[WIDTH-1:0] >> k_q;

  // Digit thresholds in eighths of the normalised divisor range, indexed by the three
  // divisor bits below its leading one; the table keeps |P| <= 2/3 * B every step.
  always_comb begin
    m1 = b_q[WIDTH-2] ? 6'sd3 : 6'sd2;
    case (b_q[WIDTH-2 -: 3])
      3'd0:    m2 = 6'sd6;
      3'd1:    m2 = 6'sd7;
      3'd2:    m2 = 6'sd8;
      3'd3:    m2 = 6'sd8;
      3'd4:    m2 = 6'sd9;
      3'd5:    m2 = 6'sd10;
      3'd6:    m2 = 6'sd10;
      default: m2 = 6'sd11;
    endcase
  end

  always_comb begin
    if (w_est >= m2)       digit = D_P2;
    else if (w_est >= m1)  digit = D_P1;
    else if (w_est >= -m1) digit = D_Z;
    else if (w_est >= -m2) digit = D_M1;
    else                   digit = D_M2;
  end

  // On-the-fly conversion: QM tracks Q-1 so negative digits never need a borrow chain.
  always_comb begin
    case (digit)
      D_P2: begin
        p_iter  = w_shift - (b_ext << 1);
        qa_iter = {qa_q[WIDTH-3:0], 2'd2};
        qm_iter = {qa_q[WIDTH-3:0], 2'd1};
      end
      D_P1: begin
        p_iter  = w_shift - b_ext;
        qa_iter = {qa_q[WIDTH-3:0], 2'd1};
        qm_iter = {qa_q[WIDTH-3:0], 2'd0};
      end
      D_M1: begin
        p_iter  = w_shift + b_ext;
        qa_iter = {qm_q[WIDTH-3:0], 2'd3};
        qm_iter = {qm_q[WIDTH-3:0], 2'd2};
      end
      D_M2: begin
        p_iter  = w_shift + (b_ext << 1);
        qa_iter = {qm_q[WIDTH-3:0], 2'd2};
        qm_iter = {qm_q[WIDTH-3:0], 2'd1};
      end
      default: begin
        p_iter  = w_shift;
        qa_iter = {qa_q[WIDTH-3:0], 2'd0};
        qm_iter = {qm_q[WIDTH-3:0], 2'd3};
      end
    endcase
  end

  // NOTE: state register uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.beginSignal) state_d = LOAD_B;
      LOAD_B:  state_d = (bus.inbus == '0) ? OUT_Q : NORM;
      NORM:    if (b_q[WIDTH-1]) state_d = ITER;
      ITER:    if (cnt_q == LAST_ITER) state_d = CORR;
      CORR:    state_d = DENORM;
      DENORM:  state_d = OUT_Q;
      OUT_Q:   state_d = OUT_R;
      OUT_R:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.outbus      = '0;
    bus.endSignal   = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.div_by_zero = 1'b0;
    case (state_q)
      OUT_Q: begin
        bus.outbus      = quo_q;
        bus.endSignal   = 1'b1;
        bus.div_by_zero = dbz_q;
      end
      OUT_R: begin
        bus.outbus      = rem_q;
        bus.endSignal   = 1'b1;
        bus.div_by_zero = dbz_q;
      end
      default: ;
    endcase
  end

  // NOTE: every next-state value is defaulted to its register first, so no latch is inferred.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    k_d   = k_q;
    cnt_d = cnt_q;
    qa_d  = qa_q;
    qm_d  = qm_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
`ifdef SRT4_SIGNED_EN
    sa_d  = sa_q;
    sb_d  = sb_q;
`endif
    case (state_q)
      IDLE: if (bus.beginSignal) begin
`ifdef SRT4_SIGNED_EN
        a_d  = magnitude(bus.inbus);
        sa_d = bus.inbus[WIDTH-1];
`else
        a_d  = bus.inbus;
`endif
        p_d   = '0;
        k_d   = '0;
        cnt_d = '0;
        dbz_d = 1'b0;
      end
      LOAD_B: begin
`ifdef SRT4_SIGNED_EN
        b_d  = magnitude(bus.inbus);
        sb_d = bus.inbus[WIDTH-1];
`else
        b_d  = bus.inbus;
`endif
        if (bus.inbus == '0) begin
          quo_d = '1;
`ifdef SRT4_SIGNED_EN
          rem_d = sa_q ? -a_q : a_q;
`else
          rem_d = a_q;
`endif
          dbz_d = 1'b1;
        end
      end
      NORM: begin
        if (!b_q[WIDTH-1]) begin
          b_d        = b_q << 1;
          {p_d, a_d} = {p_q[PW-2:0], a_q, 1'b0};
          k_d        = k_q + KW'(1);
        end else begin
          // The quotient can need one digit of weight 2^WIDTH; retiring it here keeps the
          // first residual in range. Its quotient contribution vanishes modulo 2^WIDTH.
          if ({p_q[PW-2:0], 1'b0} >= b_ext) p_d = p_q - b_ext;
          qa_d  = '0;
          qm_d  = '1;
          cnt_d = '0;
        end
      end
      ITER: begin
        p_d   = p_iter;
        a_d   = a_q << 2;
        qa_d  = qa_iter;
        qm_d  = qm_iter;
        cnt_d = cnt_q + KW'(1);
      end
      CORR: if (p_q[PW-1]) begin
        p_d  = p_q + b_ext;
        qa_d = qm_q;
      end
      DENORM: begin
`ifdef SRT4_SIGNED_EN
        quo_d = (sa_q ^ sb_q) ? -qa_q : qa_q;
        rem_d = sa_q ? -rem_mag : rem_mag;
`else
        quo_d = qa_q;
        rem_d = rem_mag;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      k_q   <= '0;
      cnt_q <= '0;
      qa_q  <= '0;
      qm_q  <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
`ifdef SRT4_SIGNED_EN
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      k_q   <= k_d;
      cnt_q <= cnt_d;
      qa_q  <= qa_d;
      qm_q  <= qm_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
`ifdef SRT4_SIGNED_EN
      sa_q  <= sa_d;
      sb_q  <= sb_d;
`endif
    end
  end

endmodule

// File: tb/tb_srt4_param_divider.sv
// Self-checking bench for srt4_param_divider: directed and random divisions against an
// arithmetic reference model, covering latency, divide-by-zero and mid-operation reset.
module tb_srt4_param_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  srt4_param_divider_if #(.WIDTH(W)) bus ();

  srt4_param_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer division plus the leading-zero count of the divisor magnitude.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output int lat);
    int k;
    logic [W-1:0] bm;
`ifdef SRT4_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    bm = (sb < 0) ? W'(-sb) : b;
    if (sb == 0) begin
      q = '1;
      r = a;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
`else
    bm = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
    k = 0;
    for (int i = W - 1; i >= 0 && bm[i] == 1'b0; i--) k++;
    lat = (b == '0) ? 2 : k + W / 2 + 5;
  endfunction

  // Starts at a negedge in IDLE (cycle 0); ends at the negedge of the IDLE cycle after OUT_R.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_at, input int rst_at, input string tag);
    logic [W-1:0] eq, er;
    int lat;
    bit seen;
    ref_div(a, b, eq, er, lat);
    seen = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      bus.beginSignal = (cyc == 0) || (cyc == pulse_at);
      bus.inbus       = (cyc == 0) ? a : (cyc == 1) ? b : W'($urandom);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, " rst outbus"}, bus.outbus, 0);
        check({tag, " rst endSignal"}, bus.endSignal, 0);
        check({tag, " rst busy"}, bus.busy, 0);
        check({tag, " rst div_by_zero"}, bus.div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.beginSignal = 1'b0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (bus.endSignal || bus.busy) seen = 1'b1;
        end
        check({tag, " quiet after rst"}, seen, 0);
        return;
      end
      if (bus.endSignal) begin
        check({tag, " latency"}, cyc, lat);
        check({tag, " quotient"}, bus.outbus, eq);
        check({tag, " dbz on Q"}, bus.div_by_zero, 32'(b == '0));
        @(negedge clk);
        bus.beginSignal = 1'b0;
        check({tag, " remainder"}, bus.outbus, er);
        check({tag, " end on R"}, bus.endSignal, 1);
        check({tag, " dbz on R"}, bus.div_by_zero, 32'(b == '0));
        @(negedge clk);
        check({tag, " idle busy"}, bus.busy, 0);
        check({tag, " idle end"}, bus.endSignal, 0);
        check({tag, " idle outbus"}, bus.outbus, 0);
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " completed"}, seen, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst             = 1'b1;
    bus.beginSignal = 1'b0;
    bus.inbus       = '0;
    repeat (2) @(negedge clk);
    check("reset outbus", bus.outbus, 0);
    check("reset endSignal", bus.endSignal, 0);
    check("reset busy", bus.busy, 0);
    check("reset div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(8'd100, 8'd7,   -1, -1, "100/7");
    run_div(8'd255, 8'd1,   -1, -1, "255/1");
    run_div(8'd3,   8'd200, -1, -1, "3/200");
    run_div(8'd200, 8'd0,   -1, -1, "200/0");
    run_div(8'd100, 8'd7,    5, -1, "100/7 stray begin");
    run_div(8'd100, 8'd7,    5,  9, "100/7 reset");
    run_div(8'd50,  8'd5,   -1, -1, "50/5");
    run_div(8'd0,   8'd1,   -1, -1, "0/1");
    run_div(8'd255, 8'd255, -1, -1, "255/255");
    run_div(8'd254, 8'd255, -1, -1, "254/255");
    run_div(8'd128, 8'd128, -1, -1, "128/128");
    run_div(8'd255, 8'd128, -1, -1, "255/128");
    run_div(8'd1,   8'd255, -1, -1, "1/255");
    run_div(8'd0,   8'd0,   -1, -1, "0/0");
`ifdef SRT4_SIGNED_EN
    run_div(8'h9C, 8'd7,  -1, -1, "-100/7");
    run_div(8'h80, 8'hFF, -1, -1, "min/-1");
    run_div(8'h80, 8'h00, -1, -1, "min/0");
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case (i % 4)
        0:       rb = W'($urandom_range(1, 15));
        1:       rb = W'($urandom_range(1, 3));
        2:       rb = (i % 10 == 2) ? '0 : W'($urandom);
        default: rb = W'($urandom_range(1, 255));
      endcase
      run_div(ra, rb, -1, -1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
